// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receive path with baud generator, optional parity,
// one or two stop bits, and sticky data/parity flags held until cleared.
module uart_receiver (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       clear_flag,
    input  logic [4:0] config_reg,
    output logic       flag_data_received,
    output logic       flag_parity_error,
    output logic [7:0] data_exracted
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
    state_t     state, state_n;
    logic [1:0] sync;
    logic       rx_s;
    logic [9:0] div, baud_cnt;
    logic       tick;
    logic [3:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [8:0] shift, shift_n;
    logic       rec_n, rec_com;
    logic       par_en, par_err;
    assign rx_s = sync[1];
    always_comb div = config_reg[1:0] == 2'b00 ? 10'd800 :
                      config_reg[1:0] == 2'b01 ? 10'd400 :
                      config_reg[1:0] == 2'b10 ? 10'd200 : 10'd100;
    assign tick    = baud_cnt == div - 10'd1;
    assign par_en  = ^config_reg[3:2];
    // odd parity (01) fails when the 9-bit XOR is 0, even (10) when it is 1
    assign par_err = par_en & ((^shift) == config_reg[3]);
    always_ff @(posedge clk) begin
        if (reset) begin
            sync     <= 2'b11;
            baud_cnt <= '0;
        end else begin
            sync     <= {sync[0], rx};
            baud_cnt <= baud_cnt >= div - 10'd1 ? '0 : baud_cnt + 10'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            rec_com <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
            rec_com <= rec_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        rec_n   = 1'b0;
        if (tick) begin
            cnt_n = cnt + 4'd1;
            case (state)
                IDLE: begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : START;
                end
                START: if (cnt == 4'd6) begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                    idx_n   = '0;
                    shift_n = rx_s ? shift : 9'd0;
                end
                DATA: if (cnt == 4'd15) begin
                    cnt_n        = '0;
                    shift_n[idx] = rx_s;
                    idx_n        = idx + 3'd1;
                    state_n      = idx != 3'd7 ? DATA : par_en ? PARITY : STOP1;
                end
                PARITY: if (cnt == 4'd15) begin
                    cnt_n      = '0;
                    shift_n[8] = rx_s;
                    state_n    = STOP1;
                end
                STOP1: if (cnt == 4'd15) begin
                    cnt_n   = '0;
                    rec_n   = ~config_reg[4];
                    state_n = config_reg[4] ? STOP2 : IDLE;
                end
                STOP2: if (cnt == 4'd15) begin
                    cnt_n   = '0;
                    rec_n   = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_data_received <= 1'b0;
            flag_parity_error  <= 1'b0;
            data_exracted      <= '0;
        end else if (rec_com) begin
            flag_data_received <= 1'b1;
            flag_parity_error  <= par_err;
            data_exracted      <= shift[7:0];
        end else if (clear_flag) begin
            flag_data_received <= 1'b0;
            flag_parity_error  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames with a scoreboard of expected bytes/parity flags,
// plus idle, glitch, clear-flag priority and mid-frame reset scenarios.
module tb_uart_receiver;
    typedef struct {logic [7:0] d; logic pe;} exp_t;
    logic       clk = 1'b0;
    logic       reset, rx, clear_flag;
    logic [4:0] cfg;
    logic       flag_data_received, flag_parity_error;
    logic [7:0] data_exracted;
    int         checks = 0, passed = 0, fails = 0, div = 100;
    logic       seen, seen_pe;
    logic [7:0] seen_data;
    exp_t       q[$];

    uart_receiver dut (
        .clk(clk), .reset(reset), .rx(rx), .clear_flag(clear_flag), .config_reg(cfg),
        .flag_data_received(flag_data_received), .flag_parity_error(flag_parity_error),
        .data_exracted(data_exracted)
    );

    always #5 clk = ~clk;

    function automatic logic pe_model(input logic [4:0] c, input logic [7:0] d, input logic p);
        logic x;
        x = ^{d, p};
        return c[3:2] == 2'b01 ? ~x : c[3:2] == 2'b10 ? x : 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // records the first clock at which flag_data_received is seen high
    task automatic wait_ticks(input int n);
        repeat (n * div) begin
            @(posedge clk);
            #1;
            if (flag_data_received && !seen) begin
                seen      = 1'b1;
                seen_data = data_exracted;
                seen_pe   = flag_parity_error;
            end
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(16);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        exp_t e;
        e.d  = d;
        e.pe = pe_model(cfg, d, p);
        q.push_back(e);
    endtask

    task automatic expect_frame(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            fails++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end else begin
            e = q.pop_front();
            check({tag, "_seen"}, 32'(seen), 32'd1);
            check({tag, "_data"}, 32'(seen_data), 32'(e.d));
            check({tag, "_pe"}, 32'(seen_pe), 32'(e.pe));
        end
    endtask

    task automatic pulse_clear();
        clear_flag = 1'b1;
        @(posedge clk);
        #1;
        clear_flag = 1'b0;
        seen = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1; clear_flag = 1'b0; cfg = 5'b00111; div = 100; seen = 1'b0;
        seen_data = '0; seen_pe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_flag", 32'(flag_data_received), 32'd0);
        check("rst_pe", 32'(flag_parity_error), 32'd0);
        check("rst_data", 32'(data_exracted), 32'h00);
        wait_ticks(160);
        check("idle_seen", 32'(seen), 32'd0);
        check("idle_data", 32'(data_exracted), 32'h00);

        push(8'hA5, 1'b0);
        send_bit(1'b0); send_byte(8'hA5); send_bit(1'b0);
        rx = 1'b1;
        wait_ticks(12);
        expect_frame("a5");

        pulse_clear();
        check("clr_flag", 32'(flag_data_received), 32'd0);
        check("clr_pe", 32'(flag_parity_error), 32'd0);
        check("clr_data", 32'(data_exracted), 32'hA5);
        push(8'hFE, 1'b0);
        send_bit(1'b0); send_byte(8'hFE); send_bit(1'b0);
        rx = 1'b1;
        wait_ticks(12);
        expect_frame("fe");

        pulse_clear();
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(24);
        check("glitch_seen", 32'(seen), 32'd0);
        check("glitch_data", 32'(data_exracted), 32'hFE);

        cfg = 5'b10010; div = 200; clear_flag = 1'b1; seen = 1'b0;
        push(8'h3C, 1'b0);
        send_bit(1'b0); send_byte(8'h3C); send_bit(1'b1);
        check("stop1_no_rec", 32'(seen), 32'd0);
        wait_ticks(12);
        expect_frame("3c_clrheld");
        clear_flag = 1'b0;
        check("3c_flag_after", 32'(flag_data_received), 32'd0);
        check("3c_data_kept", 32'(data_exracted), 32'h3C);

        cfg = 5'b00111; div = 100; seen = 1'b0;
        send_bit(1'b0); send_bit(1'b0);
        reset = 1'b1; rx = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_data", 32'(data_exracted), 32'h00);
        check("midrst_flag", 32'(flag_data_received), 32'd0);
        wait_ticks(24);
        check("midrst_seen", 32'(seen), 32'd0);
        check("sb_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
